// File: rtl/alu_cmd_queue_if.sv
// rtl/alu_cmd_queue_if.sv - producer / ALU-stage bundle for the ALU command queue
interface alu_cmd_queue_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_op;
    logic [3:0]    in_a;
    logic [3:0]    in_b;
    logic          issue_en;
    logic          flush;
    logic [3:0]    a;
    logic [3:0]    b;
    logic [2:0]    c;
    logic          issued;
    logic [CW-1:0] count;
    logic          empty;

    modport master (
        output in_valid, in_op, in_a, in_b, issue_en, flush,
        input  in_ready, a, b, c, issued, count, empty
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, issue_en, flush,
        output in_ready, a, b, c, issued, count, empty
    );
endinterface

// File: rtl/alu_cmd_queue.sv
// rtl/alu_cmd_queue.sv - FIFO of ALU commands issued one per cycle onto registered a/b/c
module alu_cmd_queue #(
    parameter int DEPTH = 4
) (
    input logic            clk,
    input logic            rst_n,
    alu_cmd_queue_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef struct packed {
        logic [2:0] op;
        logic [3:0] a;
        logic [3:0] b;
    } cmd_t;

    cmd_t          mem_q [DEPTH];
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [3:0]    a_q, a_d;
    logic [3:0]    b_q, b_d;
    logic [2:0]    c_q, c_d;
    logic          issued_q, issued_d;

    logic full;
    logic empty;
    logic push_fire;
    logic store;
    logic pop;
    cmd_t head_cmd;

    assign full      = (count_q == FULL_CNT);
    assign empty     = (count_q == '0);
    assign push_fire = bus.in_valid && !full && !bus.flush;
    // Hold opcodes complete the handshake but never occupy a slot.
    assign store     = push_fire && (bus.in_op != 3'b000);
    assign pop       = bus.issue_en && !empty && !bus.flush;
    assign head_cmd  = mem_q[head_q];

    always_comb begin
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        a_d      = a_q;
        b_d      = b_q;
        c_d      = 3'b000;
        issued_d = 1'b0;
        if (bus.flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (pop) begin
                a_d      = head_cmd.a;
                b_d      = head_cmd.b;
                c_d      = head_cmd.op;
                issued_d = 1'b1;
                head_d   = head_q + 1'b1;
            end
            if (store) begin
                tail_d = tail_q + 1'b1;
            end
            if (store && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !store) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            a_q      <= 4'h0;
            b_q      <= 4'h0;
            c_q      <= 3'b000;
            issued_q <= 1'b0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            a_q      <= a_d;
            b_q      <= b_d;
            c_q      <= c_d;
            issued_q <= issued_d;
        end
    end

    // Storage is never read before written, so it carries no reset.
    always_ff @(posedge clk) begin
        if (store) begin
            mem_q[tail_q] <= '{op: bus.in_op, a: bus.in_a, b: bus.in_b};
        end
    end

    assign bus.in_ready = !full;
    assign bus.empty    = empty;
    assign bus.count    = count_q;
    assign bus.a        = a_q;
    assign bus.b        = b_q;
    assign bus.c        = c_q;
    assign bus.issued   = issued_q;
endmodule

// File: tb/tb_alu_cmd_queue.sv
// tb/tb_alu_cmd_queue.sv - self-checking bench for alu_cmd_queue against a queue-level model
module tb_alu_cmd_queue;
    localparam int DEPTH = 4;

    logic clk;
    logic rst_n;
    int   pass_cnt;
    int   total_cnt;

    alu_cmd_queue_if #(.DEPTH(DEPTH)) bus ();

    alu_cmd_queue #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: a plain queue of accepted commands plus the last issued values.
    logic [10:0] mq[$];
    logic [3:0]  m_a      = 4'h0;
    logic [3:0]  m_b      = 4'h0;
    logic [2:0]  m_c      = 3'b000;
    logic        m_issued = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_a = 4'h0; m_b = 4'h0; m_c = 3'b000; m_issued = 1'b0;
        end else if (bus.flush) begin
            mq.delete();
            m_c = 3'b000; m_issued = 1'b0;
        end else begin
            int  pre;
            logic take;
            pre  = mq.size();
            take = bus.in_valid && (pre < DEPTH) && (bus.in_op != 3'b000);
            if (bus.issue_en && pre > 0) begin
                {m_c, m_a, m_b} = mq.pop_front();
                m_issued = 1'b1;
            end else begin
                m_c = 3'b000; m_issued = 1'b0;
            end
            if (take) mq.push_back({bus.in_op, bus.in_a, bus.in_b});
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        chk("cyc_count",    int'(bus.count),    mq.size());
        chk("cyc_in_ready", int'(bus.in_ready), int'(mq.size() < DEPTH));
        chk("cyc_empty",    int'(bus.empty),    int'(mq.size() == 0));
        chk("cyc_issued",   int'(bus.issued),   int'(m_issued));
        chk("cyc_c",        int'(bus.c),        int'(m_c));
        chk("cyc_a",        int'(bus.a),        int'(m_a));
        chk("cyc_b",        int'(bus.b),        int'(m_b));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [3:0] av, input logic [3:0] bv);
        bus.in_valid = v;
        bus.in_op    = op;
        bus.in_a     = av;
        bus.in_b     = bv;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        pass_cnt = 0;
        total_cnt = 0;
        rst_n = 1'b0;
        drive(1'b0, 3'b000, 4'h0, 4'h0);
        bus.issue_en = 1'b0;
        bus.flush    = 1'b0;
        tick();
        chk("rst_in_ready", int'(bus.in_ready), 1);
        chk("rst_empty",    int'(bus.empty),    1);
        chk("rst_count",    int'(bus.count),    0);
        chk("rst_c",        int'(bus.c),        0);
        tick();
        rst_n = 1'b1;

        // single command, one-cycle latency
        drive(1'b1, 3'b001, 4'd3, 4'd4);
        bus.issue_en = 1'b1;
        tick();
        chk("lat_not_yet", int'(bus.issued), 0);
        drive(1'b0, 3'b000, 4'h0, 4'h0);
        tick();
        chk("lat_c",      int'(bus.c),      1);
        chk("lat_a",      int'(bus.a),      3);
        chk("lat_b",      int'(bus.b),      4);
        chk("lat_issued", int'(bus.issued), 1);
        tick();
        chk("lat_c_clr",  int'(bus.c),      0);
        chk("lat_iss_clr",int'(bus.issued), 0);
        chk("lat_a_hold", int'(bus.a),      3);

        // fill with issue stalled, producer holds the fifth
        bus.issue_en = 1'b0;
        drive(1'b1, 3'b001, 4'h1, 4'h2); tick();
        drive(1'b1, 3'b010, 4'h9, 4'h3); tick();
        drive(1'b1, 3'b011, 4'hC, 4'hA); tick();
        drive(1'b1, 3'b100, 4'h5, 4'hA); tick();
        chk("full_count", int'(bus.count),    4);
        chk("full_ready", int'(bus.in_ready), 0);
        drive(1'b1, 3'b101, 4'hF, 4'h1); tick();
        chk("full_hold",  int'(bus.count),    4);
        bus.issue_en = 1'b1;
        tick();
        chk("full_pop_c",     int'(bus.c),     1);
        chk("full_pop_count", int'(bus.count), 3);
        tick();
        chk("pushpop_c",     int'(bus.c),     2);
        chk("pushpop_count", int'(bus.count), 3);
        drive(1'b0, 3'b000, 4'h0, 4'h0);
        tick(); chk("order3_c", int'(bus.c), 3);
        tick(); chk("order4_c", int'(bus.c), 4);
        tick(); chk("order5_c", int'(bus.c), 5);
        chk("order5_a", int'(bus.a), 15);
        chk("drain_count", int'(bus.count), 0);

        // hold opcode handshakes but is not stored
        drive(1'b1, 3'b000, 4'h7, 4'h7);
        chk("hold_ready", int'(bus.in_ready), 1);
        tick();
        drive(1'b0, 3'b000, 4'h0, 4'h0);
        chk("hold_count", int'(bus.count), 0);
        tick();
        chk("hold_no_issue", int'(bus.issued), 0);

        // flush beats push and pop
        bus.issue_en = 1'b0;
        drive(1'b1, 3'b110, 4'h1, 4'h1); tick();
        drive(1'b1, 3'b111, 4'h2, 4'h2); tick();
        drive(1'b1, 3'b011, 4'h3, 4'h3); tick();
        chk("pre_flush_count", int'(bus.count), 3);
        drive(1'b1, 3'b111, 4'h2, 4'h5);
        bus.issue_en = 1'b1;
        bus.flush    = 1'b1;
        chk("flush_ready", int'(bus.in_ready), 1);
        tick();
        bus.flush = 1'b0;
        drive(1'b0, 3'b000, 4'h0, 4'h0);
        chk("flush_count",  int'(bus.count),  0);
        chk("flush_empty",  int'(bus.empty),  1);
        chk("flush_issued", int'(bus.issued), 0);
        chk("flush_a_hold", int'(bus.a),      15);
        tick();
        chk("flush_dropped", int'(bus.issued), 0);

        // asynchronous reset mid-operation
        bus.issue_en = 1'b0;
        drive(1'b1, 3'b010, 4'h6, 4'h6); tick();
        drive(1'b1, 3'b001, 4'h3, 4'h3); tick();
        drive(1'b1, 3'b011, 4'h8, 4'h8); tick();
        drive(1'b0, 3'b000, 4'h0, 4'h0);
        bus.issue_en = 1'b1;
        tick();
        chk("pre_rst_c",     int'(bus.c),     2);
        chk("pre_rst_count", int'(bus.count), 2);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_count", int'(bus.count),    0);
        chk("arst_c",     int'(bus.c),        0);
        chk("arst_a",     int'(bus.a),        0);
        chk("arst_ready", int'(bus.in_ready), 1);
        #2 rst_n = 1'b1;
        drive(1'b1, 3'b110, 4'hA, 4'h5);
        tick();
        drive(1'b0, 3'b000, 4'h0, 4'h0);
        chk("post_rst_count", int'(bus.count), 1);
        tick();
        chk("post_rst_c", int'(bus.c), 6);
        chk("post_rst_a", int'(bus.a), 10);

        // mixed traffic across wrap, full and a flush, checked by the model
        for (int i = 0; i < 48; i++) begin
            drive((i % 3) != 0, 3'(i % 8), 4'(i), 4'(15 - (i % 16)));
            bus.issue_en = (i % 5) < 2;
            bus.flush    = (i == 29);
            tick();
        end
        drive(1'b0, 3'b000, 4'h0, 4'h0);
        bus.flush    = 1'b0;
        bus.issue_en = 1'b1;
        repeat (6) tick();
        chk("final_empty", int'(bus.empty), 1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/alu_cmd_queue.md
ALU_CMD_QUEUE -- requirements
Module: alu_cmd_queue

Interface
REQ-001 Parameter: DEPTH, default 4, queue entries; SHALL be a power of two, 2..16.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  producer presents a command.
REQ-005 in_ready  output  1  queue can accept; equals not full, combinational.
REQ-006 in_op  input  3  opcode: 000 hold, 001 add, 010 sub, 011 and, 100 or, 101 xor, 110 not-a, 111 not-b.
REQ-007 in_a  input  4  operand A.
REQ-008 in_b  input  4  operand B.
REQ-009 issue_en  input  1  ALU stage may take a command this cycle.
REQ-010 flush  input  1  synchronous queue clear.
REQ-011 a  output  4  registered operand A to ALU.
REQ-012 b  output  4  registered operand B to ALU.
REQ-013 c  output  3  registered opcode to ALU.
REQ-014 issued  output  1  registered; high for exactly the cycle a dequeued command is on a/b/c.
REQ-015 count  output  log2(DEPTH)+1  registered occupancy, 0..DEPTH.
REQ-016 empty  output  1  count==0, combinational from count.

Function
REQ-017 Push SHALL occur on an edge where in_valid && in_ready && !flush; {in_op,in_a,in_b} written at tail, tail advances modulo DEPTH.
REQ-018 A push with in_op==000 SHALL be accepted (handshake completes) but not stored; count and tail unchanged.
REQ-019 Pop SHALL occur on an edge where issue_en && !empty && !flush; head entry loaded into a/b/c, issued set to 1, head advances modulo DEPTH.
REQ-020 On any edge without pop, c SHALL load 000, a and b SHALL hold, issued SHALL load 0.
REQ-021 Emptiness for pop SHALL use the pre-edge count; an entry pushed at edge N is issued no earlier than edge N+1 (minimum latency one cycle, push to c valid).
REQ-022 Push and pop on the same edge SHALL leave count unchanged and both pointers advance.
REQ-023 When full, in_ready SHALL be 0 even if a pop occurs that cycle; no bypass.
REQ-024 count SHALL never exceed DEPTH nor underflow below 0; pointers wrap DEPTH-1 -> 0.
REQ-025 flush SHALL have priority over push and pop: on that edge head, tail and count load 0, c loads 000, issued loads 0, a/b hold; any in_valid in that cycle is dropped.
REQ-026 in_ready SHALL remain !full during a flush cycle; the dropped command is not retried by the queue.
REQ-027 Queue order SHALL be strict FIFO; commands leave in acceptance order.
REQ-028 issue_en low SHALL stall pops only; pushes continue until full.

Reset
REQ-029 While rst_n is low: head=0, tail=0, count=0, a=0000, b=0000, c=000, issued=0, immediately and independent of clk.
REQ-030 in_ready SHALL read 1 and empty 1 during and after reset.
REQ-031 Reset asserted mid-operation SHALL discard all stored commands; first pop after release returns the first command pushed after release.
REQ-032 Storage array contents need not be reset; never observable before being written.

Verification
REQ-033 Reset, then push {001,3,4} with issue_en=1 -> next edge c=001,a=3,b=4,issued=1; following edge c=000,issued=0,a=3,b=4.
REQ-034 issue_en=0, push 5 commands with DEPTH=4 -> count=4, in_ready=0 after 4th, 5th held by producer; raise issue_en -> 4 pops in order, then 5th accepted and issued.
REQ-035 Full queue, in_valid=1 and issue_en=1 same cycle -> pop occurs, push blocked, count=3; next cycle push accepted, count stays 3.
REQ-036 Push {000,7,7} -> in_ready handshake completes, count unchanged, no issued pulse.
REQ-037 Queue holding 3 entries, flush=1 with in_valid=1 and issue_en=1 -> next edge count=0, empty=1, c=000, issued=0, new command not stored.
REQ-038 Pulse rst_n low between edges with count=2 and c=010 -> outputs zero immediately; after release first push issues with latency one cycle.
